misc_result_acc: RTL and testbench

Frame accumulator directly downstream of the `Misc` datapath. It samples the `XOUT1`/`XOUT2` result pair under a valid/ready handshake and keeps a running sum of `XOUT1`, plus the unsigned min and max of `XOUT2`, over a frame of up to `FRAME_LEN` samples. At frame end it presents a summary record on a second valid/ready handshake.

---
 rtl/misc_result_acc.sv | 133 +++++++++++++
 tb/tb_misc_result_acc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/misc_result_acc.sv
`default_nettype none
// ============================================================================
// Module   : misc_result_acc
// Purpose  : Frame accumulator for the Misc datapath result pair. Sums XOUT1
//            and tracks the unsigned min/max of XOUT2 over a frame of up to
//            FRAME_LEN samples, then presents a summary record on a second
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW        : width of XOUT1/XOUT2
//   FRAME_LEN : samples per frame (1..255)
//   ACC_W     : SUM width (>= DW)
// Ports
//   CLK       in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   IN_VALID  in   XOUT1/XOUT2 carry a sample
//   IN_READY  out  block can accept a sample (low only while a record is held)
//   XOUT1     in   sample summed into SUM
//   XOUT2     in   sample tracked for min/max (unsigned)
//   FLUSH     in   close the current frame early
//   OUT_VALID out  summary record valid
//   OUT_READY in   consumer takes the summary
//   SUM       out  modulo-2^ACC_W sum of XOUT1 over the frame
//   XMAX      out  max of XOUT2 over the frame
//   XMIN      out  min of XOUT2 over the frame
//   COUNT     out  number of samples in the frame
// ============================================================================
module misc_result_acc #(
    parameter int DW        = 8,
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [DW-1:0]    XOUT1,
    input  logic [DW-1:0]    XOUT2,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] SUM,
    output logic [DW-1:0]    XMAX,
    output logic [DW-1:0]    XMIN,
    output logic [7:0]       COUNT
);

    localparam logic [7:0] C_FRAME_LEN = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_sum;
    logic [DW-1:0]    r_xmax;
    logic [DW-1:0]    r_xmin;
    logic [7:0]       r_count;

    // Zero-extended sample and next count are shared by the IDLE load and
    // the ACCUM update paths.
    logic [ACC_W-1:0] w_xout1_ext;
    logic [7:0]       w_count_inc;

    assign w_xout1_ext = ACC_W'(XOUT1);
    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_sum   <= '0;
            r_xmax  <= '0;
            r_xmin  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A flush with no sample is dropped: empty frames are
                    // never emitted.
                    if (IN_VALID) begin
                        r_sum   <= w_xout1_ext;
                        r_xmax  <= XOUT2;
                        r_xmin  <= XOUT2;
                        r_count <= 8'd1;
                        if ((C_FRAME_LEN == 8'd1) || FLUSH) begin
                            r_state <= ST_EMIT;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (IN_VALID) begin
                        // Sum wraps modulo 2^ACC_W by design.
                        r_sum   <= r_sum + w_xout1_ext;
                        r_xmax  <= (XOUT2 > r_xmax) ? XOUT2 : r_xmax;
                        r_xmin  <= (XOUT2 < r_xmin) ? XOUT2 : r_xmin;
                        r_count <= w_count_inc;
                        if ((w_count_inc == C_FRAME_LEN) || FLUSH) begin
                            r_state <= ST_EMIT;
                        end
                    end else if (FLUSH) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // Accumulators hold; FLUSH and IN_VALID are ignored.
                    if (OUT_READY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register, so neither
    // depends combinationally on any input.
    assign IN_READY  = (r_state != ST_EMIT);
    assign OUT_VALID = (r_state == ST_EMIT);

    assign SUM   = r_sum;
    assign XMAX  = r_xmax;
    assign XMIN  = r_xmin;
    assign COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_misc_result_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_misc_result_acc
// Purpose  : Directed self-checking bench for misc_result_acc. Main instance
//            uses FRAME_LEN=4, ACC_W=16; a second instance uses FRAME_LEN=2,
//            ACC_W=8 to exercise sum wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misc_result_acc;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  XOUT1;
    logic [7:0]  XOUT2;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] SUM;
    logic [7:0]  XMAX;
    logic [7:0]  XMIN;
    logic [7:0]  COUNT;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [7:0]  w_xout1;
    logic [7:0]  w_xout2;
    logic        w_flush;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [7:0]  w_sum;
    logic [7:0]  w_xmax;
    logic [7:0]  w_xmin;
    logic [7:0]  w_count;

    int checks = 0;
    int errors = 0;

    misc_result_acc #(.DW(8), .FRAME_LEN(4), .ACC_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .XOUT1(XOUT1), .XOUT2(XOUT2), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .SUM(SUM), .XMAX(XMAX), .XMIN(XMIN), .COUNT(COUNT)
    );

    misc_result_acc #(.DW(8), .FRAME_LEN(2), .ACC_W(8)) dut_w (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(w_in_valid), .IN_READY(w_in_ready),
        .XOUT1(w_xout1), .XOUT2(w_xout2), .FLUSH(w_flush),
        .OUT_VALID(w_out_valid), .OUT_READY(w_out_ready),
        .SUM(w_sum), .XMAX(w_xmax), .XMIN(w_xmin), .COUNT(w_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one sample on the main instance and let it be taken.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic fl);
        IN_VALID = 1'b1;
        XOUT1    = a;
        XOUT2    = b;
        FLUSH    = fl;
        tick();
        IN_VALID = 1'b0;
        FLUSH    = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        IN_VALID = 1'b0; XOUT1 = '0; XOUT2 = '0; FLUSH = 1'b0; OUT_READY = 1'b1;
        w_in_valid = 1'b0; w_xout1 = '0; w_xout2 = '0; w_flush = 1'b0; w_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got in_ready=%b out_valid=%b exp 1 0", IN_READY, OUT_VALID);
        end
        checks++;
        if (SUM !== 16'd0 || XMAX !== 8'd0 || XMIN !== 8'd0 || COUNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs got sum=%0d max=%0d min=%0d cnt=%0d exp all 0", SUM, XMAX, XMIN, COUNT);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        OUT_READY = 1'b1;
        send(8'd10, 8'd5, 1'b0);
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL full_midframe got in_ready=%b out_valid=%b exp 1 0", IN_READY, OUT_VALID);
        end
        send(8'd20, 8'd200, 1'b0);
        send(8'd30, 8'd7, 1'b0);
        send(8'd40, 8'd9, 1'b0);
        checks++;
        if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL full_emit_flags got out_valid=%b in_ready=%b exp 1 0", OUT_VALID, IN_READY);
        end
        checks++;
        if (SUM !== 16'd100 || XMAX !== 8'd200 || XMIN !== 8'd5 || COUNT !== 8'd4) begin
            errors++;
            $display("FAIL full_record got sum=%0d max=%0d min=%0d cnt=%0d exp 100 200 5 4", SUM, XMAX, XMIN, COUNT);
        end
        tick();
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL full_after_hs got in_ready=%b out_valid=%b exp 1 0", IN_READY, OUT_VALID);
        end
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        send(8'd10, 8'd5, 1'b0);
        send(8'd20, 8'd200, 1'b0);
        send(8'd30, 8'd7, 1'b0);
        send(8'd40, 8'd9, 1'b0);
        // Three stalled EMIT cycles; stray valid/flush must not disturb the record.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || SUM !== 16'd100 ||
                XMAX !== 8'd200 || XMIN !== 8'd5 || COUNT !== 8'd4) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got ov=%b ir=%b sum=%0d max=%0d min=%0d cnt=%0d exp 1 0 100 200 5 4",
                         i, OUT_VALID, IN_READY, SUM, XMAX, XMIN, COUNT);
            end
            IN_VALID = 1'b1; XOUT1 = 8'd77; XOUT2 = 8'd250; FLUSH = 1'b1;
            if (i == 2) OUT_READY = 1'b1;
            tick();
        end
        IN_VALID = 1'b0; FLUSH = 1'b0;
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || COUNT !== 8'd4) begin
            errors++;
            $display("FAIL bp_after_hs got ir=%b ov=%b cnt=%0d exp 1 0 4", IN_READY, OUT_VALID, COUNT);
        end
    endtask

    task automatic test_early_flush();
        OUT_READY = 1'b1;
        send(8'd1, 8'd9, 1'b0);
        send(8'd2, 8'd3, 1'b0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b1 || SUM !== 16'd3 || XMAX !== 8'd9 || XMIN !== 8'd3 || COUNT !== 8'd2) begin
            errors++;
            $display("FAIL flush_record got ov=%b sum=%0d max=%0d min=%0d cnt=%0d exp 1 3 9 3 2",
                     OUT_VALID, SUM, XMAX, XMIN, COUNT);
        end
        tick();
        // Flush in IDLE with no sample must not produce an empty record.
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL flush_idle cyc%0d got ov=%b ir=%b exp 0 1", i, OUT_VALID, IN_READY);
            end
            tick();
        end
    endtask

    task automatic test_flush_with_accept();
        OUT_READY = 1'b1;
        send(8'd1, 8'd9, 1'b0);
        send(8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd1, 1'b1);
        checks++;
        if (OUT_VALID !== 1'b1 || SUM !== 16'd7 || XMAX !== 8'd9 || XMIN !== 8'd1 || COUNT !== 8'd3) begin
            errors++;
            $display("FAIL flush_accept got ov=%b sum=%0d max=%0d min=%0d cnt=%0d exp 1 7 9 1 3",
                     OUT_VALID, SUM, XMAX, XMIN, COUNT);
        end
        tick();
        // First sample with FLUSH closes a 1-sample frame straight from IDLE.
        send(8'd33, 8'd44, 1'b1);
        checks++;
        if (OUT_VALID !== 1'b1 || SUM !== 16'd33 || XMAX !== 8'd44 || XMIN !== 8'd44 || COUNT !== 8'd1) begin
            errors++;
            $display("FAIL flush_first got ov=%b sum=%0d max=%0d min=%0d cnt=%0d exp 1 33 44 44 1",
                     OUT_VALID, SUM, XMAX, XMIN, COUNT);
        end
        tick();
    endtask

    task automatic test_wrap();
        w_out_ready = 1'b1;
        w_in_valid = 1'b1; w_xout1 = 8'd200; w_xout2 = 8'd50;
        tick();
        w_xout1 = 8'd100; w_xout2 = 8'd60;
        tick();
        w_in_valid = 1'b0;
        checks++;
        if (w_out_valid !== 1'b1 || w_sum !== 8'd44 || w_xmax !== 8'd60 || w_xmin !== 8'd50 || w_count !== 8'd2) begin
            errors++;
            $display("FAIL wrap_record got ov=%b sum=%0d max=%0d min=%0d cnt=%0d exp 1 44 60 50 2",
                     w_out_valid, w_sum, w_xmax, w_xmin, w_count);
        end
        tick();
        checks++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_after_hs got ov=%b ir=%b exp 0 1", w_out_valid, w_in_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        OUT_READY = 1'b0;
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        checks++;
        if (OUT_VALID !== 1'b1 || COUNT !== 8'd2) begin
            errors++;
            $display("FAIL rst_emit_setup got ov=%b cnt=%0d exp 1 2", OUT_VALID, COUNT);
        end
        // Still well before the next rising edge.
        RST_N = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || SUM !== 16'd0 ||
            XMAX !== 8'd0 || XMIN !== 8'd0 || COUNT !== 8'd0) begin
            errors++;
            $display("FAIL rst_async got ov=%b ir=%b sum=%0d max=%0d min=%0d cnt=%0d exp 0 1 0 0 0 0",
                     OUT_VALID, IN_READY, SUM, XMAX, XMIN, COUNT);
        end
        tick();
        RST_N = 1'b1;
        tick();
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_release got ov=%b ir=%b exp 0 1", OUT_VALID, IN_READY);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_early_flush();
        test_flush_with_accept();
        test_wrap();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
